// File: rtl/match_log_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : match_log_defs (package)
//  Description : Shared defaults for the match event logger and the pulse
//                width contract of the upstream 1101 sequence detector.
//  Revision    : 1.0  initial release
// ============================================================================
package match_log_defs;

    // Default timestamp counter width
    localparam int TS_W_DEF      = 16;
    // Default FIFO depth (power of two, >= 2)
    localparam int DEPTH_DEF     = 4;
    // Default saturating match counter width
    localparam int CNT_W_DEF     = 8;
    // The detector's match output is high for exactly one cycle per match
    localparam int MATCH_PULSE_W = 1;

endpackage
`default_nettype wire

// File: rtl/match_event_logger_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word fall-through FIFO. Occupancy is
//                tracked in a level counter; pointers wrap naturally.
//                A push into a full FIFO is accepted when a pop occurs in
//                the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo
    import match_log_defs::*;
#(
    parameter int WIDTH = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_DEPTH_L = c_LVL_W'(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_LVL_W-1:0] level_q, level_d;
    logic               w_pop_eff;
    logic               w_push_eff;

    // Next-state: flush wins; otherwise accept pop when non-empty and push
    // when there is room (room may come from a same-cycle pop).
    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        w_pop_eff  = pop && (level_q != '0);
        w_push_eff = push && ((level_q != c_DEPTH_L) || w_pop_eff);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_push_eff) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (w_pop_eff) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (w_push_eff && !w_pop_eff) begin
                level_d = level_q + 1'b1;
            end else if (w_pop_eff && !w_push_eff) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    assign valid = (level_q != '0);
    assign dout  = valid ? mem_q[rd_ptr_q] : '0;
    assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/match_event_logger.sv
`default_nettype none
// ============================================================================
//  Module      : match_event_logger
//  Description : Time-stamps each one-cycle match pulse with a free-running
//                cycle counter, queues timestamps in a FWFT FIFO for a
//                valid/ready reader, and keeps a saturating match count plus
//                a sticky overflow flag for dropped matches.
//  Revision    : 1.0  initial release
// ============================================================================
module match_event_logger
    import match_log_defs::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       match_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TS_W-1:0]            out_ts,
    output logic [CNT_W-1:0]           count,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int c_LVL_W = $clog2(DEPTH) + 1;
    localparam logic [c_LVL_W-1:0] c_DEPTH_L = c_LVL_W'(DEPTH);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             w_capture;
    logic             w_pop;
    logic             w_drop;
    logic             w_valid;
    logic [c_LVL_W-1:0] w_level;

    // Clear suppresses capture and pop; a capture is dropped only when the
    // FIFO is full and no pop frees a slot in the same cycle.
    always_comb begin
        w_capture = en && match_in && !clr;
        w_pop     = w_valid && out_ready && !clr;
        w_drop    = w_capture && (w_level == c_DEPTH_L) && !w_pop;
    end

    // Timestamp, saturating count and sticky overflow next-state
    always_comb begin
        ts_d       = ts_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clr) begin
            ts_d       = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (en) begin
                ts_d = ts_q + 1'b1;
            end
            if (w_capture && (count_q != '1)) begin
                count_d = count_q + 1'b1;
            end
            if (w_drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clr),
        .push  (w_capture),
        .pop   (w_pop),
        .din   (ts_q),
        .dout  (out_ts),
        .valid (w_valid),
        .level (w_level)
    );

    assign out_valid = w_valid;
    assign level     = w_level;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire
